// File: rtl/cache_hit_stats.sv
// cache_hit_stats: per-channel cache hit/miss counters with a snapshot/acknowledge
// readout port. Live counters keep running while a coherent snapshot is held.
// Optional feature: define CACHE_STATS_SAT_EN to make counters saturate instead of wrap.
module cache_hit_stats #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       acc_valid,
  input  logic [NUM_CH-1:0]       acc_hit,
  input  logic                    clear,
  input  logic                    snap_req,
  input  logic                    snap_ack,
  output logic [NUM_CH*CNT_W-1:0] hit_count,
  output logic [NUM_CH*CNT_W-1:0] miss_count,
  output logic [NUM_CH*CNT_W-1:0] snap_hit,
  output logic [NUM_CH*CNT_W-1:0] snap_miss,
  output logic                    snap_valid,
  output logic [NUM_CH-1:0]       ovf
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e state_q, state_d;
  logic   capture;

  logic [NUM_CH*CNT_W-1:0] snap_hit_q, snap_miss_q;

  // Returns {overflow, next value} for a single +1 step.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
`ifdef CACHE_STATS_SAT_EN
    if (&v) begin
      return {1'b1, v};
    end
    return {1'b0, v + CntOne};
`else
    return {&v, v + CntOne};
`endif
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             hit_inc, miss_inc;
    logic [CNT_W:0]   hit_bump, miss_bump;
    logic [CNT_W-1:0] hit_q, miss_q;
    logic             ovf_q;

    assign hit_inc   = acc_valid[c] & acc_hit[c];
    assign miss_inc  = acc_valid[c] & ~acc_hit[c];
    assign hit_bump  = bump(hit_q);
    assign miss_bump = bump(miss_q);

    // Channel counters and sticky overflow; clear wins over same-cycle accesses.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hit_q  <= '0;
        miss_q <= '0;
        ovf_q  <= 1'b0;
      end else if (clear) begin
        hit_q  <= '0;
        miss_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (hit_inc) begin
          hit_q <= hit_bump[CNT_W-1:0];
        end
        if (miss_inc) begin
          miss_q <= miss_bump[CNT_W-1:0];
        end
        if ((hit_inc & hit_bump[CNT_W]) | (miss_inc & miss_bump[CNT_W])) begin
          ovf_q <= 1'b1;
        end
      end
    end

    assign hit_count[c*CNT_W +: CNT_W]  = hit_q;
    assign miss_count[c*CNT_W +: CNT_W] = miss_q;
    assign ovf[c]                       = ovf_q;
  end

  // Snapshot FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot FSM next state: a request alone never releases or overwrites a held snapshot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (snap_req) state_d = StHold;
      StHold: if (snap_ack && !snap_req) state_d = StIdle;
    endcase
  end

  // Snapshot FSM outputs: capture strobe and registered valid flag.
  always_comb begin
    capture    = 1'b0;
    snap_valid = 1'b0;
    unique case (state_q)
      StIdle: capture = snap_req;
      StHold: begin
        capture    = snap_ack & snap_req;
        snap_valid = 1'b1;
      end
    endcase
  end

  // Snapshot registers sample the live registers before this edge's increment/clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_hit_q  <= '0;
      snap_miss_q <= '0;
    end else if (capture) begin
      snap_hit_q  <= hit_count;
      snap_miss_q <= miss_count;
    end
  end

  assign snap_hit  = snap_hit_q;
  assign snap_miss = snap_miss_q;

endmodule

// File: tb/tb_cache_hit_stats.sv
// Scoreboard bench for cache_hit_stats: a default instance (CNT_W=10) and a narrow
// instance (CNT_W=4) share stimulus; expectations are queued, a monitor compares.
module tb_cache_hit_stats;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  acc_valid, acc_hit;
  logic        clear, snap_req, snap_ack;

  logic [19:0] hc, mc, sh, sm;
  logic        sv;
  logic [1:0]  ov;
  logic [7:0]  hc4, mc4, sh4, sm4;
  logic        sv4;
  logic [1:0]  ov4;

  cache_hit_stats dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .acc_valid (acc_valid),
    .acc_hit   (acc_hit),
    .clear     (clear),
    .snap_req  (snap_req),
    .snap_ack  (snap_ack),
    .hit_count (hc),
    .miss_count(mc),
    .snap_hit  (sh),
    .snap_miss (sm),
    .snap_valid(sv),
    .ovf       (ov)
  );

  cache_hit_stats #(.NUM_CH(2), .CNT_W(4)) dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .acc_valid (acc_valid),
    .acc_hit   (acc_hit),
    .clear     (clear),
    .snap_req  (snap_req),
    .snap_ack  (snap_ack),
    .hit_count (hc4),
    .miss_count(mc4),
    .snap_hit  (sh4),
    .snap_miss (sm4),
    .snap_valid(sv4),
    .ovf       (ov4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    sel;
    int    due;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

`ifdef CACHE_STATS_SAT_EN
  localparam int Ovf16 = 15;
  localparam int Ovf17 = 15;
`else
  localparam int Ovf16 = 0;
  localparam int Ovf17 = 1;
`endif

  function automatic int probe(input int sel);
    case (sel)
      0:       return int'(hc[9:0]);
      1:       return int'(hc[19:10]);
      2:       return int'(mc[9:0]);
      3:       return int'(mc[19:10]);
      4:       return int'(sh[9:0]);
      5:       return int'(sh[19:10]);
      6:       return int'(sm[9:0]);
      7:       return int'(sm[19:10]);
      8:       return int'(sv);
      9:       return int'(ov);
      10:      return int'(hc4[3:0]);
      11:      return int'(ov4);
      12:      return int'(mc4[3:0]);
      13:      return int'(sh4[3:0]);
      default: return int'(sv4);
    endcase
  endfunction

  exp_t e;
  int   act;

  // Monitor: compare every queued expectation once its cycle has come.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      act = probe(e.sel);
      n_chk++;
      if (act == e.exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
    end
  end

  task automatic chk(input string nm, input int sel, input int ex);
    sb.push_back('{nm, sel, cyc + 1, ex});
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] h, input logic c,
                      input logic r, input logic a);
    @(posedge clk);
    #1;
    acc_valid = v;
    acc_hit   = h;
    clear     = c;
    snap_req  = r;
    snap_ack  = a;
  endtask

  task automatic hits0(input int n);
    for (int i = 0; i < n; i++) step(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    acc_valid = '0;
    acc_hit   = '0;
    clear     = 1'b0;
    snap_req  = 1'b0;
    snap_ack  = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    acc_valid = '0;
    acc_hit   = '0;
    clear     = 1'b0;
    snap_req  = 1'b0;
    snap_ack  = 1'b0;

    for (int s = 0; s < 15; s++) chk($sformatf("reset_sel%0d", s), s, 0);
    release_reset();

    // Interleaved counting; ch1 misses alongside ch0 traffic.
    for (int i = 0; i < 10; i++) begin
      step({(i < 5) ? 1'b1 : 1'b0, 1'b1}, {1'b0, (i < 7) ? 1'b1 : 1'b0}, 1'b0, 1'b0, 1'b0);
    end
    step(2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("cnt_hit0", 0, 7);
    chk("cnt_miss0", 2, 3);
    chk("cnt_hit1", 1, 0);
    chk("cnt_miss1", 3, 5);
    chk("cnt4_hit0", 10, 7);
    chk("cnt4_miss0", 12, 3);
    chk("cnt_ovf", 9, 0);

    // Reset mid-count.
    step(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    drive_reset();
    chk("rst_hit0", 0, 0);
    chk("rst_miss0", 2, 0);
    chk("rst_miss1", 3, 0);
    chk("rst_hit4", 10, 0);
    chk("rst_valid", 8, 0);
    release_reset();

    // Overflow boundary on the 4-bit instance.
    hits0(15);
    chk("ovf_at_max", 10, 15);
    chk("ovf_not_yet", 11, 0);
    hits0(1);
    chk("ovf_16", 10, Ovf16);
    chk("ovf_flag16", 11, 1);
    chk("ovf_wide16", 0, 16);
    chk("ovf_wide_flag", 9, 0);
    hits0(1);
    chk("ovf_17", 10, Ovf17);
    chk("ovf_flag17", 11, 1);
    chk("ovf_wide17", 0, 17);
    step(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("clr_hit4", 10, 0);
    chk("clr_ovf4", 11, 0);
    chk("clr_hit0", 0, 0);

    // Snapshot handshake.
    hits0(12);
    for (int i = 0; i < 4; i++) step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("snap_hit0", 4, 12);
    chk("snap_miss0", 6, 4);
    chk("snap_hit1", 5, 0);
    chk("snap_valid", 8, 1);
    chk("snap4_hit0", 13, 12);
    step(2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
    hits0(2);
    chk("hold_live", 0, 15);
    chk("hold_snap", 4, 12);
    chk("hold_valid", 8, 1);
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("ack_valid", 8, 0);
    chk("ack_snap", 4, 12);
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("idle_ack", 8, 0);

    // Read-and-clear.
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("clr_keeps_snap", 4, 12);
    hits0(9);
    step(2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("rc_snap_hit", 4, 9);
    chk("rc_snap_miss", 6, 0);
    chk("rc_live", 0, 0);
    chk("rc_valid", 8, 1);

    // Ack and request together in hold recapture pre-increment values.
    hits0(5);
    step(2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
    chk("recap_snap", 4, 5);
    chk("recap_live", 0, 6);
    chk("recap_valid", 8, 1);
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("final_valid", 8, 0);
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d checks left unexamined, required 0", sb.size());
      n_chk += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1);
  end

endmodule
